fixed_vector_mult_arbiter: RTL

Round-robin arbiter that shares one external `fixed_vector_mult` datapath (elementwise vector multiply behind a one-entry register slice) between `NUM_REQ` requesters. Each requester presents a (data, weight) vector pair with one valid/ready handshake. The arbiter issues the pair to the multiplier and records the requester index in an in-flight tag FIFO. It then routes each returned product vector back to the requester that issued it, in issue order.

---
 rtl/fixed_vector_mult_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fixed_vector_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fixed_vector_mult_arbiter
// Purpose : round-robin sharing of one fixed_vector_mult datapath; optional
//           per-requester issue counters under FIXED_VECTOR_MULT_ARB_PERF_EN
// Revision: 1.0
// ============================================================================
module fixed_vector_mult_arbiter #(
  parameter int IN_WIDTH     = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUT_WIDTH    = IN_WIDTH + WEIGHT_WIDTH,
  parameter int IN_SIZE      = 4,
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0][IN_SIZE-1:0][IN_WIDTH-1:0]     req_data_in,
  input  logic [NUM_REQ-1:0][IN_SIZE-1:0][WEIGHT_WIDTH-1:0] req_weight,
  input  logic [NUM_REQ-1:0]                            req_valid,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [IN_SIZE-1:0][IN_WIDTH-1:0]              mult_data_in,
  output logic [IN_SIZE-1:0][WEIGHT_WIDTH-1:0]          mult_weight,
  output logic                                          mult_data_in_valid,
  output logic                                          mult_weight_valid,
  input  logic                                          mult_data_in_ready,
  input  logic                                          mult_weight_ready,
  input  logic [IN_SIZE-1:0][OUT_WIDTH-1:0]             mult_data_out,
  input  logic                                          mult_data_out_valid,
  output logic                                          mult_data_out_ready,
  output logic [IN_SIZE-1:0][OUT_WIDTH-1:0]             resp_data,
  output logic [NUM_REQ-1:0]                            resp_valid,
  input  logic [NUM_REQ-1:0]                            resp_ready
`ifdef FIXED_VECTOR_MULT_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]                      perf_issue_count
`endif
);

  localparam int c_ptr_w = $clog2(NUM_REQ);
  localparam int c_fp_w  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int c_cnt_w = $clog2(MAX_INFLIGHT + 1);
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(MAX_INFLIGHT);
  localparam logic [c_fp_w-1:0]  c_fp_last  = c_fp_w'(MAX_INFLIGHT - 1);
  localparam logic [c_ptr_w-1:0] c_req_last = c_ptr_w'(NUM_REQ - 1);
  localparam logic [c_ptr_w:0]   c_nreq     = (c_ptr_w + 1)'(NUM_REQ);

  logic [c_ptr_w-1:0]                     r_rr_ptr;
  logic [MAX_INFLIGHT-1:0][c_ptr_w-1:0]   r_tag_mem;
  logic [c_fp_w-1:0]                      r_wr_ptr;
  logic [c_fp_w-1:0]                      r_rd_ptr;
  logic [c_cnt_w-1:0]                     r_count;

  logic [c_ptr_w-1:0] w_grant;
  logic [c_ptr_w-1:0] w_head;
  logic [c_ptr_w:0]   w_sum;
  logic               w_found;
  logic               w_full;
  logic               w_empty;
  logic               w_issue;
  logic               w_accept;
  logic               w_pop;

  // Scan upward from the pointer with wrap; with nothing pending the pointer itself is driven.
  always_comb begin
    w_grant = r_rr_ptr;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_ptr_w + 1)'(i);
      if (w_sum >= c_nreq) begin
        w_sum = w_sum - c_nreq;
      end
      if (!w_found && req_valid[w_sum[c_ptr_w-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_sum[c_ptr_w-1:0];
      end
    end
  end

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  // Full blocks issue even when a pop coincides, keeping resp_ready off the req_ready path.
  assign w_issue  = !rst && (|req_valid) && !w_full;
  assign w_accept = w_issue && mult_data_in_ready && mult_weight_ready;

  assign mult_data_in_valid = w_issue;
  assign mult_weight_valid  = w_issue;
  assign mult_data_in       = req_data_in[w_grant];
  assign mult_weight        = req_weight[w_grant];

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  assign w_head              = r_tag_mem[r_rd_ptr];
  assign mult_data_out_ready = !rst && !w_empty && resp_ready[w_head];
  assign w_pop               = mult_data_out_valid && mult_data_out_ready;
  assign resp_data           = mult_data_out;

  always_comb begin
    resp_valid = '0;
    if (!rst && !w_empty && mult_data_out_valid) begin
      resp_valid[w_head] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_mem[r_wr_ptr] <= w_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= (r_wr_ptr == c_fp_last) ? '0 : r_wr_ptr + c_fp_w'(1);
        r_rr_ptr <= (w_grant == c_req_last) ? '0 : w_grant + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_fp_last) ? '0 : r_rd_ptr + c_fp_w'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIXED_VECTOR_MULT_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] r_perf;

  generate
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_perf
      always_ff @(posedge clk) begin
        if (rst) begin
          r_perf[r] <= '0;
        end else if (req_ready[r] && req_valid[r] && (r_perf[r] != 32'hFFFF_FFFF)) begin
          r_perf[r] <= r_perf[r] + 32'd1;
        end
      end
    end
  endgenerate

  assign perf_issue_count = r_perf;
`endif

endmodule
`default_nettype wire
